// File: rtl/gimbal_30km.sv
// gimbal_30km -- pitch-program controller.
// Engages the gimbal once integrated height reaches the dense-air threshold,
// latches the no-air reference point, and then continuously recomputes the
// vehicle angular rate w = v * RATE_SCALE / (R_EARTH + altitude) with a
// bit-serial restoring divider (one quotient bit per clock).
// Optional feature macro: GIMBAL_SAT_EN -- when defined, every quotient is
// clamped to MAX_ANG_RATE before it reaches angularVelocity.
module gimbal_30km #(
  parameter int           N                = 64,
  parameter logic [N-1:0] THRESHOLD        = 64'd30_000_000_000_000,
  parameter logic [N-1:0] R_EARTH          = 64'd6_371_000_000_000_000,
  parameter logic [N-1:0] RATE_SCALE       = 64'd1_000_000_000,
  parameter logic [N-1:0] LAUNCH_DOWNRANGE = 64'd0
`ifdef GIMBAL_SAT_EN
  ,
  parameter logic [N-1:0] MAX_ANG_RATE     = 64'd2_000_000
`endif
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic [N-1:0] velocity,
  input  logic [N-1:0] height,
  input  logic [N-1:0] currentAltitude,
  output logic [N-1:0] angularVelocity,
  output logic [N-1:0] noairAltitude,
  output logic [N-1:0] noairDistance,
  output logic         gimbalEnable
);

  // Dividend is the full double-width product; the counter must reach NW-1.
  localparam int          NW        = 2 * N;
  localparam int          CW        = $clog2(NW) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(NW - 1);

  typedef enum logic {
    ST_IDLE,  // waiting to capture operands (only leaves when engaged)
    ST_DIV    // shifting out quotient bits
  } div_state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic          r_engaged;
  logic [N-1:0]  r_noair_alt;
  logic [N-1:0]  r_noair_dist;
  logic [N-1:0]  r_rate;

  div_state_t    r_state;
  logic [NW-1:0] r_num;     // dividend, shifted left; becomes the quotient
  logic [N-1:0]  r_den;     // divisor captured at start
  logic [N-1:0]  r_rem;     // partial remainder, always < r_den
  logic [CW-1:0] r_count;   // iteration index within the current division

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  div_state_t    w_state_next;
  logic          w_start;
  logic          w_finish;

  logic [NW-1:0] w_num_cap;
  logic [N:0]    w_den_sum;
  logic [N-1:0]  w_den_cap;

  logic [N:0]    w_rem_shift;
  logic          w_qbit;
  logic [N-1:0]  w_rem_diff;
  logic [N-1:0]  w_rem_next;
  logic [NW-1:0] w_quot;
  logic [N-1:0]  w_rate_result;

  // ---------------------------------------------------------------------------
  // Operand capture: scaled speed and (saturating) distance from Earth centre
  // ---------------------------------------------------------------------------
  assign w_num_cap = NW'(velocity) * NW'(RATE_SCALE);
  assign w_den_sum = {1'b0, R_EARTH} + {1'b0, currentAltitude};
  assign w_den_cap = w_den_sum[N] ? {N{1'b1}} : w_den_sum[N-1:0];

  // ---------------------------------------------------------------------------
  // One restoring-division step. The remainder is kept below the divisor, so
  // after shifting in the next dividend bit it needs one extra bit, and the
  // difference (taken only when it is non-negative) fits back into N bits.
  // ---------------------------------------------------------------------------
  assign w_rem_shift = {r_rem, r_num[NW-1]};
  assign w_qbit      = (w_rem_shift >= {1'b0, r_den});
  assign w_rem_diff  = w_rem_shift[N-1:0] - r_den;
  assign w_rem_next  = w_qbit ? w_rem_diff : w_rem_shift[N-1:0];
  assign w_quot      = {r_num[NW-2:0], w_qbit};

  // Final result: optional clamp, then N-bit saturation. A zero divisor makes
  // every step subtract nothing, yielding an all-ones quotient, but it is
  // forced explicitly so the result does not depend on that side effect.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_rate_result = w_quot[N-1:0];
`ifdef GIMBAL_SAT_EN
    if ((r_den == '0) || (w_quot > NW'(MAX_ANG_RATE))) begin
      w_rate_result = MAX_ANG_RATE;
    end
`else
    if ((r_den == '0) || (|w_quot[NW-1:N])) begin
      w_rate_result = {N{1'b1}};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Engage latch: first edge with height at or above threshold; sticky
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      r_engaged    <= 1'b0;
      r_noair_alt  <= '0;
      r_noair_dist <= '0;
    end else if (!r_engaged && (height >= THRESHOLD)) begin
      r_engaged    <= 1'b1;
      r_noair_alt  <= height;
      r_noair_dist <= LAUNCH_DOWNRANGE;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Divider control: next state plus start/finish strobes. While engaged the
  // idle state lasts exactly one edge, giving an update period of NW+1 clocks.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_engaged) begin
          w_start      = 1'b1;
          w_state_next = ST_DIV;
        end
      end
      ST_DIV: begin
        if (r_count == LAST_ITER) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider datapath: capture operands on start, one quotient bit per clock
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_num   <= '0;
      r_den   <= '0;
      r_rem   <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_num   <= w_num_cap;
      r_den   <= w_den_cap;
      r_rem   <= '0;
      r_count <= '0;
    end else if (r_state == ST_DIV) begin
      r_num   <= w_quot;
      r_rem   <= w_rem_next;
      r_count <= r_count + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output rate register: updated only on the final division step
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rate <= '0;
    end else if (w_finish) begin
      r_rate <= w_rate_result;
    end
  end

  assign angularVelocity = r_rate;
  assign noairAltitude   = r_noair_alt;
  assign noairDistance   = r_noair_dist;
  assign gimbalEnable    = r_engaged;

endmodule

// File: tb/tb_gimbal_30km.sv
// tb_gimbal_30km -- self-checking bench for gimbal_30km.
// Directed scenarios (reset, threshold, rate, sticky, mid-division reset,
// clamp) followed by randomized stimulus. A behavioural timeline model computes
// each expected rate with plain wide arithmetic and schedules when it appears.
module tb_gimbal_30km;

  localparam int          N          = 64;
  localparam logic [63:0] THRESHOLD  = 64'd30_000_000_000_000;
  localparam logic [63:0] R_EARTH    = 64'd6_371_000_000_000_000;
  localparam logic [63:0] RATE_SCALE = 64'd1_000_000_000;
  localparam logic [63:0] MAX_RATE   = 64'd2_000_000;
  localparam logic [63:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetb;
  logic [63:0] velocity;
  logic [63:0] height;
  logic [63:0] currentAltitude;
  logic [63:0] angularVelocity;
  logic [63:0] noairAltitude;
  logic [63:0] noairDistance;
  logic        gimbalEnable;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  gimbal_30km dut (
    .clk             (clk),
    .resetb          (resetb),
    .velocity        (velocity),
    .height          (height),
    .currentAltitude (currentAltitude),
    .angularVelocity (angularVelocity),
    .noairAltitude   (noairAltitude),
    .noairDistance   (noairDistance),
    .gimbalEnable    (gimbalEnable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected rate straight from the formula: wide product, saturating
  // denominator, integer division, optional clamp, then 64-bit saturation.
  function automatic logic [63:0] ref_rate(input logic [63:0] v, input logic [63:0] alt);
    logic [127:0] num;
    logic [64:0]  sum;
    logic [127:0] den;
    logic [127:0] q;
    num = 128'(v) * 128'(RATE_SCALE);
    sum = 65'(R_EARTH) + 65'(alt);
    den = (sum > 65'(ALL_ONES)) ? 128'(ALL_ONES) : 128'(sum);
    q   = (den == 0) ? {128{1'b1}} : num / den;
`ifdef GIMBAL_SAT_EN
    if (q > 128'(MAX_RATE)) q = 128'(MAX_RATE);
`endif
    return (q > 128'(ALL_ONES)) ? ALL_ONES : q[63:0];
  endfunction

  // Timeline model: engage on first qualifying edge; while engaged, a
  // computation starts, its result appears 2N edges later, and the next one
  // starts on the following edge.
  logic        m_en, m_busy;
  logic [63:0] m_alt, m_dist, m_av, m_pending;
  int          m_cnt;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_en      <= 1'b0;
      m_alt     <= '0;
      m_dist    <= '0;
      m_av      <= '0;
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      m_pending <= '0;
    end else begin
      if (!m_en && height >= THRESHOLD) begin
        m_en   <= 1'b1;
        m_alt  <= height;
        m_dist <= '0;
      end
      if (m_en) begin
        if (!m_busy) begin
          m_busy    <= 1'b1;
          m_cnt     <= 2 * N;
          m_pending <= ref_rate(velocity, currentAltitude);
        end else if (m_cnt == 1) begin
          m_av   <= m_pending;
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("mon_en",   64'(gimbalEnable), 64'(m_en));
      check("mon_alt",  noairAltitude,     m_alt);
      check("mon_dist", noairDistance,     m_dist);
      check("mon_rate", angularVelocity,   m_av);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] sat_exp;
    resetb          = 1'b0;
    height          = 64'd40_000_000_000_000;
    velocity        = '0;
    currentAltitude = '0;

    // 1. Reset holds everything at zero even with height above threshold.
    tick(3);
    check("rst_en",   64'(gimbalEnable), 64'd0);
    check("rst_alt",  noairAltitude,     64'd0);
    check("rst_dist", noairDistance,     64'd0);
    check("rst_rate", angularVelocity,   64'd0);
    mon_on = 1'b1;
    resetb = 1'b1;
    tick(1);
    check("rel_en",  64'(gimbalEnable), 64'd1);
    check("rel_alt", noairAltitude,     64'd40_000_000_000_000);

    // 2. Threshold ramp: one below does not engage, equal does.
    resetb          = 1'b0;
    height          = 64'd29_999_999_999_999;
    velocity        = 64'd2_000_000_000;
    currentAltitude = 64'd29_000_000_000_000;
    tick(1);
    resetb = 1'b1;
    tick(3);
    check("thr_below_en",  64'(gimbalEnable), 64'd0);
    check("thr_below_alt", noairAltitude,     64'd0);
    height = THRESHOLD;
    tick(1);
    check("thr_eq_en",   64'(gimbalEnable), 64'd1);
    check("thr_eq_alt",  noairAltitude,     THRESHOLD);
    check("thr_eq_dist", noairDistance,     64'd0);

    // 3. First rate appears 2N+1 edges after the engage edge.
    tick(2 * N);
    check("rate_early", angularVelocity, 64'd0);
    tick(1);
    check("rate_312", angularVelocity, 64'd312);

    // 4. Sticky engage with height dropped to zero.
    height = '0;
    tick(5);
    check("sticky_en",  64'(gimbalEnable), 64'd1);
    check("sticky_alt", noairAltitude,     THRESHOLD);

    // 5. Reset ten clocks into a division clears outputs immediately.
    height = 64'd40_000_000_000_000;
    tick(6);
    resetb = 1'b0;
    #1;
    check("midrst_en",   64'(gimbalEnable), 64'd0);
    check("midrst_alt",  noairAltitude,     64'd0);
    check("midrst_rate", angularVelocity,   64'd0);
    tick(1);
    resetb = 1'b1;
    tick(1);
    check("reeng_en", 64'(gimbalEnable), 64'd1);
    tick(2 * N);
    check("reeng_early", angularVelocity, 64'd0);
    tick(1);
    check("reeng_rate", angularVelocity, 64'd312);

    // 6. Large velocity: clamped or raw quotient depending on build.
    resetb   = 1'b0;
    velocity = 64'd100_000_000_000_000;
    tick(1);
    resetb = 1'b1;
    tick(1 + 2 * N + 1);
`ifdef GIMBAL_SAT_EN
    sat_exp = 64'd2_000_000;
`else
    sat_exp = 64'd15_625_000;
`endif
    check("big_rate", angularVelocity, sat_exp);

    // 7. Randomized stimulus, checked by the monitor every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      resetb = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       velocity = 64'($urandom);
          1:       velocity = {$urandom, $urandom};
          default: velocity = 64'd1_000_000_000 + 64'($urandom_range(0, 1_000_000));
        endcase
        case ($urandom_range(0, 3))
          0:       currentAltitude = 64'($urandom) * 64'd100_000;
          1:       currentAltitude = {$urandom, $urandom};
          2:       currentAltitude = ALL_ONES - 64'($urandom);
          default: currentAltitude = 64'd0;
        endcase
        height = ($urandom_range(0, 49) == 0) ? THRESHOLD + 64'($urandom_range(0, 3))
                                              : THRESHOLD - 64'($urandom_range(1, 1000));
      end
    end
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
